// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared definitions for the reset sequencer.
//   rst_seq_state_e : sequencer FSM states (2-bit encoding)
//   PLL_RST_PULSE   : length in cycles of the clock-generator reset pulse
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } rst_seq_state_e;

  localparam int unsigned PLL_RST_PULSE = 4;

endpackage

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: 1-bit two-flop synchroniser with asynchronous clear.
//   clk     : destination clock, rising edge
//   a_reset : asynchronous active-high clear (both flops to 0)
//   d_i     : asynchronous input
//   q_o     : synchronised output, two clk cycles of latency
module rst_seq_sync (
  input  logic clk,
  input  logic a_reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: power-on / software reset sequencer.
// Waits for the clock generator to lock, holds every domain in reset for
// HOLD_CYCLES, then releases the domains one at a time (bit 0 first),
// STEP_CYCLES apart. Loss of lock or a software request restarts the sequence.
//
// Ports:
//   clk            : clock, rising edge
//   a_reset        : asynchronous active-high reset
//   pll_locked_i   : clock-generator lock, asynchronous to clk
//   sw_reset_req_i : synchronous software reset request
//   rst_out_o      : per-domain reset, active-high
//   done_o         : all domains released
//   pll_rst_o      : reset pulse to the clock generator (watchdog build only)
//   lock_err_o     : sticky lock-timeout flag (watchdog build only)
//
// Build option: define RST_SEQ_WDOG_EN to enable the lock watchdog. Without
// it pll_rst_o and lock_err_o are tied low and WAIT_LOCK waits forever.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS  = 3,
  parameter int HOLD_CYCLES  = 16,
  parameter int STEP_CYCLES  = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   a_reset,
  input  logic                   pll_locked_i,
  input  logic                   sw_reset_req_i,
  output logic [NUM_DOMAINS-1:0] rst_out_o,
  output logic                   done_o,
  output logic                   pll_rst_o,
  output logic                   lock_err_o
);

  localparam int HS_MAX  = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int MAX_CYC = (HS_MAX > LOCK_TIMEOUT) ? HS_MAX : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  logic locked_s;

  rst_seq_sync u_lock_sync (
    .clk     (clk),
    .a_reset (a_reset),
    .d_i     (pll_locked_i),
    .q_o     (locked_s)
  );

  rst_seq_state_e         state_q,   state_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic [IDX_W-1:0]       idx_q,     idx_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   done_q,    done_d;
  logic                   abort;

  // Lock loss and a software request share one restart path, so both in the
  // same cycle still produce a single transition back to WAIT_LOCK.
  assign abort = !locked_s || sw_reset_req_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;

    if (state_q != ST_WAIT_LOCK && abort) begin
      state_d   = ST_WAIT_LOCK;
      rst_out_d = '1;
      done_d    = 1'b0;
      cnt_d     = '0;
      idx_d     = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_out_d[0] = 1'b0;
            cnt_d        = '0;
            // A single domain goes straight to RUN; RELEASE would be empty.
            if (NUM_DOMAINS == 1) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STEP_LAST) begin
            rst_out_d[idx_q] = 1'b0;
            cnt_d            = '0;
            if (idx_q == LAST_IDX) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state_d = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
    end
  end

  assign rst_out_o = rst_out_q;
  assign done_o    = done_q;

`ifdef RST_SEQ_WDOG_EN
  localparam int               PULSE_W    = $clog2(PLL_RST_PULSE);
  localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PLL_RST_PULSE - 1);

  logic [CNT_W-1:0]   wdog_cnt_q,  wdog_cnt_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic               pll_rst_q,   pll_rst_d;
  logic               lock_err_q,  lock_err_d;

  // A started pulse always runs to full length; the wait count restarts
  // from zero only once the pulse has ended.
  always_comb begin
    wdog_cnt_d  = wdog_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    pll_rst_d   = pll_rst_q;
    lock_err_d  = lock_err_q;

    if (pll_rst_q) begin
      if (pulse_cnt_q == PULSE_LAST) begin
        pll_rst_d   = 1'b0;
        pulse_cnt_d = '0;
        wdog_cnt_d  = '0;
      end else begin
        pulse_cnt_d = pulse_cnt_q + 1'b1;
      end
    end else if (state_q == ST_WAIT_LOCK && !locked_s) begin
      if (wdog_cnt_q == WDOG_LAST) begin
        pll_rst_d   = 1'b1;
        lock_err_d  = 1'b1;
        pulse_cnt_d = '0;
        wdog_cnt_d  = '0;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
    end else begin
      wdog_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      wdog_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      pll_rst_q   <= 1'b0;
      lock_err_q  <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      pll_rst_q   <= pll_rst_d;
      lock_err_q  <= lock_err_d;
    end
  end

  assign pll_rst_o  = pll_rst_q;
  assign lock_err_o = lock_err_q;
`else
  assign pll_rst_o  = 1'b0;
  assign lock_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: self-checking bench for rst_sequencer
// (NUM_DOMAINS=3, HOLD=16, STEP=8, LOCK_TIMEOUT=64). Works with or without
// RST_SEQ_WDOG_EN defined.
module tb_rst_sequencer;

  localparam int N     = 3;
  localparam int HOLD  = 16;
  localparam int STEP  = 8;
  localparam int TMO   = 64;
  localparam int PULSE = 4;

  logic         clk;
  logic         a_reset;
  logic         pll_locked_i;
  logic         sw_reset_req_i;
  logic [N-1:0] rst_out_o;
  logic         done_o;
  logic         pll_rst_o;
  logic         lock_err_o;

  int total;
  int bad;
  int printed;

  rst_sequencer #(
    .NUM_DOMAINS  (N),
    .HOLD_CYCLES  (HOLD),
    .STEP_CYCLES  (STEP),
    .LOCK_TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .a_reset        (a_reset),
    .pll_locked_i   (pll_locked_i),
    .sw_reset_req_i (sw_reset_req_i),
    .rst_out_o      (rst_out_o),
    .done_o         (done_o),
    .pll_rst_o      (pll_rst_o),
    .lock_err_o     (lock_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: m_t counts edges since lock was seen stable; domain i
  // is released once m_t reaches HOLD + i*STEP.
  logic m_s1;
  logic m_ls;
  logic m_active;
  logic m_err;
  int   m_t;
  int   m_wait;
  int   m_pulse;

  always @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      m_s1     <= 1'b0;
      m_ls     <= 1'b0;
      m_active <= 1'b0;
      m_err    <= 1'b0;
      m_t      <= 0;
      m_wait   <= 0;
      m_pulse  <= 0;
    end else begin
      if (m_active) begin
        if (!m_ls || sw_reset_req_i) m_active <= 1'b0;
        else if (m_t < 1000) m_t <= m_t + 1;
      end else if (m_ls) begin
        m_active <= 1'b1;
        m_t      <= 0;
      end
      m_ls <= m_s1;
      m_s1 <= pll_locked_i;
`ifdef RST_SEQ_WDOG_EN
      if (m_pulse > 0) begin
        m_pulse <= m_pulse - 1;
        if (m_pulse == 1) m_wait <= 0;
      end else if (!m_active && !m_ls) begin
        if (m_wait + 1 == TMO) begin
          m_pulse <= PULSE;
          m_err   <= 1'b1;
          m_wait  <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else begin
        m_wait <= 0;
      end
`endif
    end
  end

  function automatic logic [N-1:0] expRst();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = !(m_active && m_t >= HOLD + i * STEP);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      if (printed < 50) begin
        printed++;
        $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
      end
    end
  endtask

  task automatic applyStimulus(input logic lock, input logic sw);
    pll_locked_i   = lock;
    sw_reset_req_i = sw;
  endtask

  task automatic compareModel();
    checkOutput("model_rst_out", 32'(rst_out_o), 32'(expRst()));
    checkOutput("model_done", 32'(done_o), 32'(m_active && m_t >= HOLD + (N - 1) * STEP));
    checkOutput("model_pll_rst", 32'(pll_rst_o), 32'(m_pulse > 0));
    checkOutput("model_lock_err", 32'(lock_err_o), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compareModel();
  endtask

  // which: 0..N-1 bit released, N done high, -1 all resets high,
  // -2 pll_rst high, -3 pll_rst low
  function automatic bit cond(input int which);
    if (which >= 0 && which < N) return rst_out_o[which] == 1'b0;
    if (which == N)  return done_o == 1'b1;
    if (which == -1) return rst_out_o == {N{1'b1}};
    if (which == -2) return pll_rst_o == 1'b1;
    return pll_rst_o == 1'b0;
  endfunction

  task automatic measure(input int which, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < 400) begin
      tick();
      n++;
      hit = cond(which);
    end
    if (!hit) n = -1;
  endtask

  task automatic doReset();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    a_reset = 1'b1;
    #1;
    checkOutput("reset_rst_out", 32'(rst_out_o), 32'h7);
    checkOutput("reset_done", 32'(done_o), 32'h0);
    checkOutput("reset_pll_rst", 32'(pll_rst_o), 32'h0);
    checkOutput("reset_lock_err", 32'(lock_err_o), 32'h0);
    @(negedge clk);
    a_reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    total   = 0;
    bad     = 0;
    printed = 0;
    a_reset = 1'b1;
    applyStimulus(1'b0, 1'b0);

    doReset();

`ifdef RST_SEQ_WDOG_EN
    $display("[TB] watchdog: lock never asserts");
    measure(-2, n); checkOutput("wdog_first_pulse_edge", 32'(n), 32'd64);
    checkOutput("wdog_lock_err_set", 32'(lock_err_o), 32'h1);
    measure(-3, n); checkOutput("wdog_pulse_length", 32'(n), 32'd4);
    checkOutput("wdog_lock_err_held", 32'(lock_err_o), 32'h1);
    measure(-2, n); checkOutput("wdog_second_pulse_gap", 32'(n), 32'd64);
`else
    $display("[TB] no watchdog: lock low for 10000 cycles");
    for (int c = 0; c < 10000; c++) tick();
    checkOutput("nowdog_pll_rst", 32'(pll_rst_o), 32'h0);
    checkOutput("nowdog_lock_err", 32'(lock_err_o), 32'h0);
    checkOutput("nowdog_rst_out", 32'(rst_out_o), 32'h7);
`endif

    $display("[TB] power-up sequence");
    doReset();
    applyStimulus(1'b1, 1'b0);
    measure(0, n); checkOutput("pwrup_bit0_edge", 32'(n), 32'd19);
    measure(1, n); checkOutput("pwrup_bit1_step", 32'(n), 32'd8);
    measure(2, n); checkOutput("pwrup_bit2_step", 32'(n), 32'd8);
    checkOutput("pwrup_done", 32'(done_o), 32'h1);

    $display("[TB] software reset pulse in RUN");
    tick(); tick(); tick();
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0);
    checkOutput("swrst_rst_out", 32'(rst_out_o), 32'h7);
    checkOutput("swrst_done", 32'(done_o), 32'h0);
    measure(0, n); checkOutput("swrst_bit0_edge", 32'(n), 32'd17);
    measure(1, n); checkOutput("swrst_bit1_step", 32'(n), 32'd8);
    measure(2, n); checkOutput("swrst_bit2_step", 32'(n), 32'd8);

    $display("[TB] lock loss during RELEASE");
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0);
    measure(0, n); checkOutput("lockloss_bit0_edge", 32'(n), 32'd17);
    applyStimulus(1'b0, 1'b0);
    measure(-1, n); checkOutput("lockloss_latency", 32'(n), 32'd3);
    checkOutput("lockloss_done", 32'(done_o), 32'h0);
    applyStimulus(1'b1, 1'b0);
    measure(0, n); checkOutput("relock_bit0_edge", 32'(n), 32'd19);
    measure(1, n); checkOutput("relock_bit1_step", 32'(n), 32'd8);

    $display("[TB] async reset mid-RELEASE");
    @(posedge clk);
    #2;
    a_reset = 1'b1;
    #1;
    checkOutput("areset_rst_out", 32'(rst_out_o), 32'h7);
    checkOutput("areset_done", 32'(done_o), 32'h0);
    checkOutput("areset_lock_err", 32'(lock_err_o), 32'h0);
    @(negedge clk);
    a_reset = 1'b0;
    measure(0, n); checkOutput("areset_bit0_edge", 32'(n), 32'd19);

    $display("[TB] randomized lock / software request traffic");
    for (int c = 0; c < 3000; c++) begin
      logic lock_n;
      lock_n = pll_locked_i;
      if ($urandom_range(0, 99) == 0) lock_n = ~lock_n;
      applyStimulus(lock_n, $urandom_range(0, 59) == 0);
      tick();
    end
    applyStimulus(pll_locked_i, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
